// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK count sequencer.
//   JK_*     : two-bit J/K excitation codes, J in bit 1, K in bit 0
//   mode_t   : sequencer operating mode as presented on the mode port
//   state_t  : sequencer FSM state
package jk_seq_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears q
//   jk    : excitation, jk[1]=J, jk[0]=K
//   q     : stored bit
module jk_cell
    import jk_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] jk,
    output logic       q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            case (jk)
                JK_RST:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                JK_TGL:  q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_count_sequencer.sv
// Sequencer wrapped around a WIDTH-bit register of JK flip-flops. A start
// request runs a fixed number of clock steps in hold, up, down or load mode,
// generating the per-bit J/K excitation on every step.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : request pulse, sampled only while idle
//   mode      : 00 hold, 01 up, 10 down, 11 load (latched on start)
//   load_val  : load target (latched on start)
//   steps     : number of clock edges to run (latched on start)
//   q         : JK register contents
//   jk        : excitation applied this cycle, jk[2i+1]=J_i, jk[2i]=K_i
//   busy      : high whenever the FSM is not idle
//   done      : one-cycle completion pulse
//   tc        : q == MODULUS-1
//   state_dbg : current FSM state, for observation only
//
// Handshake: start is a level sampled on each rising edge while idle; a start
// seen while busy is dropped. Completion is signalled by a single-cycle done
// pulse with no acknowledge.
module jk_count_sequencer
    import jk_seq_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10,
    parameter int STEP_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     load_val,
    input  logic [STEP_W-1:0]    steps,
    output logic [WIDTH-1:0]     q,
    output logic [2*WIDTH-1:0]   jk,
    output logic                 busy,
    output logic                 done,
    output logic                 tc,
    output logic [1:0]           state_dbg
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable in the compare.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

    state_t              state;
    mode_t               mode_r;
    logic [WIDTH-1:0]    load_r;
    logic [STEP_W-1:0]   remaining;
    logic [WIDTH-1:0]    q_next;
    logic [2*WIDTH-1:0]  jk_c;

    // Target value of the register for the latched mode.
    always_comb begin
        q_next = q;
        case (mode_r)
            MODE_UP:   q_next = (q == MAX_Q) ? '0 : q + WIDTH'(1);
            MODE_DOWN: q_next = (q == '0) ? MAX_Q : q - WIDTH'(1);
            MODE_LOAD: q_next = ({1'b0, load_r} >= MOD_W) ? '0 : load_r;
            default:   q_next = q;
        endcase
    end

    // Excitation: only bits that must change get a non-hold code. Counting
    // modes toggle; load uses explicit set/reset so it is idempotent, which is
    // why repeated load steps settle to all-hold.
    always_comb begin
        jk_c = '0;
        if (state == ST_RUN) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (q[i] != q_next[i]) begin
                    if (mode_r == MODE_LOAD) begin
                        jk_c[2*i +: 2] = q_next[i] ? JK_SET : JK_RST;
                    end else begin
                        jk_c[2*i +: 2] = JK_TGL;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_r    <= MODE_HOLD;
            load_r    <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_r    <= mode_t'(mode);
                        load_r    <= load_val;
                        remaining <= steps;
                        busy      <= 1'b1;
                        if (steps != '0) begin
                            state <= ST_RUN;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    remaining <= remaining - STEP_W'(1);
                    // This edge performs the final register update.
                    if (remaining == STEP_W'(1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .jk    (jk_c[2*i +: 2]),
            .q     (q[i])
        );
    end

    assign jk        = jk_c;
    assign tc        = (q == MAX_Q);
    assign state_dbg = state;

endmodule

// File: tb/tb_jk_count_sequencer.sv
module tb_jk_count_sequencer;

    localparam int W  = 4;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    mode;
    logic [W-1:0]  load_val;
    logic [SW-1:0] steps;
    logic [W-1:0]  q;
    logic [2*W-1:0] jk;
    logic          busy;
    logic          done;
    logic          tc;
    logic [1:0]    state_dbg;

    int n_vec = 0;
    int n_err = 0;

    jk_count_sequencer #(.WIDTH(4), .MODULUS(10), .STEP_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .load_val  (load_val),
        .steps     (steps),
        .q         (q),
        .jk        (jk),
        .busy      (busy),
        .done      (done),
        .tc        (tc),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] lv;
        logic [SW-1:0] steps;
        logic         poke;       // pulse start mid-run (must be ignored)
        logic         chk_first;  // compare first-step jk against first_jk
        logic [7:0]   first_jk;
        logic [W-1:0] end_q;
    } vec_t;

    vec_t tbl[10];

    logic [W-1:0] mq;              // model register value
    logic [11:0]  exp_q[$];        // {jk expected before edge, q expected after edge}

    function automatic logic [3:0] nxt(input logic [3:0] c, input logic [1:0] md,
                                       input logic [3:0] lv);
        case (md)
            2'b01:   return (c == 4'd9) ? 4'd0 : c + 4'd1;
            2'b10:   return (c == 4'd0) ? 4'd9 : c - 4'd1;
            2'b11:   return (lv >= 4'd10) ? 4'd0 : lv;
            default: return c;
        endcase
    endfunction

    function automatic logic [7:0] exc(input logic [3:0] c, input logic [3:0] n,
                                       input logic [1:0] md);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (c[i] != n[i]) begin
                if (md == 2'b11) r[2*i +: 2] = n[i] ? 2'b10 : 2'b01;
                else             r[2*i +: 2] = 2'b11;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_q"}, 32'(q), 32'(mq));
        chk({name, "_jk"}, 32'(jk), 32'h0);
        chk({name, "_busy"}, 32'(busy), 32'h0);
        chk({name, "_done"}, 32'(done), 32'h0);
    endtask

    // driver + scoreboard for one start request
    task automatic run_op(input vec_t v);
        logic [3:0]  c;
        logic [3:0]  n;
        logic [11:0] e;
        c = mq;
        for (int s = 0; s < int'(v.steps); s++) begin
            n = nxt(c, v.mode, v.lv);
            exp_q.push_back({exc(c, n, v.mode), n});
            c = n;
        end
        @(negedge clk);
        start = 1'b1; mode = v.mode; load_val = v.lv; steps = v.steps;
        @(posedge clk); #1;
        // scramble inputs to show they were latched
        start = 1'b0;
        mode = 2'($urandom_range(0, 3));
        load_val = 4'($urandom_range(0, 15));
        steps = 8'($urandom_range(1, 255));
        for (int s = 1; s <= int'(v.steps); s++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'(exp_q.size()), 32'd1);
                break;
            end
            e = exp_q.pop_front();
            chk("run_jk", 32'(jk), 32'(e[11:4]));
            if (s == 1 && v.chk_first) chk("first_jk", 32'(jk), 32'(v.first_jk));
            chk("run_busy", 32'(busy), 32'h1);
            chk("run_done", 32'(done), 32'h0);
            if (v.poke && s == 2) begin
                start = 1'b1; mode = 2'b11; load_val = 4'd3; steps = 8'd1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            chk("run_q", 32'(q), 32'(e[3:0]));
            chk("run_tc", 32'(tc), 32'(e[3:0] == 4'd9));
        end
        mq = c;
        @(negedge clk);
        chk("end_done", 32'(done), 32'h1);
        chk("end_busy", 32'(busy), 32'h1);
        chk("end_jk", 32'(jk), 32'h0);
        chk("end_q", 32'(q), 32'(v.end_q));
        chk("end_state", 32'(state_dbg), 32'h2);
        @(negedge clk);
        chk("post_done", 32'(done), 32'h0);
        chk("post_busy", 32'(busy), 32'h0);
        chk("post_q", 32'(q), 32'(v.end_q));
    endtask

    initial begin
        //           mode   lv     steps  poke  chkf  first_jk        end_q
        tbl[0] = '{2'b01, 4'd0,  8'd12, 1'b0, 1'b1, 8'b00_00_00_11, 4'd2};
        tbl[1] = '{2'b11, 4'd0,  8'd1,  1'b0, 1'b1, 8'b00_00_01_00, 4'd0};
        tbl[2] = '{2'b10, 4'd0,  8'd3,  1'b0, 1'b1, 8'b11_00_00_11, 4'd7};
        tbl[3] = '{2'b11, 4'd9,  8'd1,  1'b0, 1'b1, 8'b10_01_01_00, 4'd9};
        tbl[4] = '{2'b11, 4'd6,  8'd2,  1'b0, 1'b1, 8'b01_10_10_01, 4'd6};
        tbl[5] = '{2'b11, 4'd12, 8'd1,  1'b0, 1'b1, 8'b00_01_01_00, 4'd0};
        tbl[6] = '{2'b00, 4'd5,  8'd4,  1'b0, 1'b1, 8'b00_00_00_00, 4'd0};
        tbl[7] = '{2'b01, 4'd0,  8'd0,  1'b0, 1'b0, 8'b00_00_00_00, 4'd0};
        tbl[8] = '{2'b10, 4'd0,  8'd1,  1'b0, 1'b1, 8'b11_00_00_11, 4'd9};
        tbl[9] = '{2'b01, 4'd0,  8'd5,  1'b1, 1'b1, 8'b11_00_00_11, 4'd4};

        rst_n = 1'b0; start = 1'b0; mode = 2'b00; load_val = '0; steps = '0;
        mq = 4'd0;

        // reset state
        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk("reset_state", 32'(state_dbg), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_idle("idle");
        end

        // table-driven operations
        for (int i = 0; i < 10; i++) run_op(tbl[i]);

        // reset in step 4 of a 10-step up run from q=4
        @(negedge clk);
        start = 1'b1; mode = 2'b01; steps = 8'd10;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_q", 32'(q), 32'd7);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        mq = 4'd0;
        chk_idle("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle("after_rst");
        end

        // a fresh start works after reset
        run_op('{2'b01, 4'd0, 8'd2, 1'b0, 1'b1, 8'b00_00_00_11, 4'd2});

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
